freq_sched_ctrl: RTL and testbench

Tone-table scheduler for the frequency selector datapath. Software loads up to 16 (slot, frequency-word) entries into a shadow bank and commits them atomically. The block streams the active entries round-robin to the downstream tone generator over a valid/ready handshake. A commit takes effect only at a sweep boundary, so a running sweep is never torn.

---
 rtl/freq_sched_ctrl.sv | 140 ++++++++++++++
 tb/tb_freq_sched_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_sched_ctrl.sv
// Tone-table scheduler: shadow/active slot banks with atomic commit at sweep
// boundaries, streaming valid slots round-robin over a valid/ready handshake.
module freq_sched_ctrl #(
  parameter int N_SLOTS = 16,
  parameter int SLOT_W  = 4,
  parameter int FREQ_W  = 14
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              cfg_wr_en,
  input  logic [19:0]       cfg_wr_data,
  input  logic              commit,
  input  logic              clear,
  input  logic              run,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FREQ_W-1:0] out_freq,
  output logic [SLOT_W-1:0] out_slot,
  output logic              out_last,
  output logic              commit_pending,
  output logic [SLOT_W:0]   active_count,
  output logic [15:0]       sweep_count,
  output logic              busy
);

  // state | meaning
  // IDLE  | not streaming; waits for a pending commit or run with a non-empty table
  // RUN   | presenting beats from the active bank
  // SWAP  | one-cycle shadow-to-active copy
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SWAP = 2'd2} state_t;

  state_t             state;
  logic [FREQ_W-1:0]  shadow_freq [N_SLOTS];
  logic [FREQ_W-1:0]  active_freq [N_SLOTS];
  logic [N_SLOTS-1:0] shadow_valid, active_valid, shadow_valid_nxt;
  logic [SLOT_W-1:0]  ptr, lo_idx, hi_idx, nx_idx, sh_lo_idx, ld_idx;
  logic [SLOT_W:0]    sh_count;
  logic [SLOT_W-1:0]  wr_slot;
  logic [FREQ_W-1:0]  wr_freq;
  logic               handshake;
  logic               unused_cfg_bits;

  assign wr_slot         = cfg_wr_data[16 +: SLOT_W];
  assign wr_freq         = cfg_wr_data[FREQ_W-1:0];
  assign unused_cfg_bits = ^cfg_wr_data[15:14];
  assign handshake       = out_valid & out_ready;
  assign busy            = (state != IDLE);

  // Priority searches over the banks; downward loops leave the lowest hit.
  always_comb begin
    lo_idx    = '0;
    hi_idx    = '0;
    nx_idx    = '0;
    sh_lo_idx = '0;
    sh_count  = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (active_valid[i]) lo_idx = SLOT_W'(i);
      if (shadow_valid[i]) sh_lo_idx = SLOT_W'(i);
      if (active_valid[i] && (SLOT_W'(i) > ptr)) nx_idx = SLOT_W'(i);
    end
    for (int i = 0; i < N_SLOTS; i++) begin
      if (active_valid[i]) hi_idx = SLOT_W'(i);
      sh_count = sh_count + (SLOT_W+1)'(shadow_valid[i]);
    end
    ld_idx = (state == RUN && !out_last) ? nx_idx : lo_idx;
  end

  // Clear first, then the write, so a same-cycle write survives the clear.
  always_comb begin
    shadow_valid_nxt = clear ? '0 : shadow_valid;
    if (cfg_wr_en) shadow_valid_nxt[wr_slot] = 1'b1;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        shadow_freq[i] <= '0;
        active_freq[i] <= '0;
      end
      shadow_valid   <= '0;
      active_valid   <= '0;
      state          <= IDLE;
      ptr            <= '0;
      out_valid      <= 1'b0;
      out_freq       <= '0;
      out_slot       <= '0;
      out_last       <= 1'b0;
      commit_pending <= 1'b0;
      active_count   <= '0;
      sweep_count    <= '0;
    end else begin
      shadow_valid <= shadow_valid_nxt;
      if (cfg_wr_en) shadow_freq[wr_slot] <= wr_freq;

      if (state == SWAP) commit_pending <= 1'b0;
      else if (commit)   commit_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (commit_pending) begin
            state <= SWAP;
          end else if (run && active_count != '0) begin
            state     <= RUN;
            out_valid <= 1'b1;
            ptr       <= ld_idx;
            out_slot  <= ld_idx;
            out_freq  <= active_freq[ld_idx];
            out_last  <= (ld_idx == hi_idx);
          end
        end
        SWAP: begin
          for (int i = 0; i < N_SLOTS; i++) active_freq[i] <= shadow_freq[i];
          active_valid <= shadow_valid;
          active_count <= sh_count;
          ptr          <= sh_lo_idx;
          state        <= IDLE;
        end
        RUN: begin
          if (handshake) begin
            if (out_last) sweep_count <= sweep_count + 16'd1;
            if (out_last && commit_pending) begin
              state     <= SWAP;
              out_valid <= 1'b0;
            end else if (!run) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end else begin
              ptr      <= ld_idx;
              out_slot <= ld_idx;
              out_freq <= active_freq[ld_idx];
              out_last <= (ld_idx == hi_idx);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_sched_ctrl.sv
// Scoreboard bench for freq_sched_ctrl: stimulus queues expected beats, a
// negedge monitor pops and compares on every handshake and checks stall holds.
module tb_freq_sched_ctrl;
  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_wr_en = 1'b0, commit = 1'b0, clear = 1'b0, run = 1'b0, out_ready = 1'b0;
  logic [19:0] cfg_wr_data = '0;
  logic        out_valid, out_last, commit_pending, busy;
  logic [13:0] out_freq;
  logic [3:0]  out_slot;
  logic [4:0]  active_count;
  logic [15:0] sweep_count;

  freq_sched_ctrl dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_wr_data(cfg_wr_data),
    .commit(commit), .clear(clear), .run(run), .out_valid(out_valid), .out_ready(out_ready),
    .out_freq(out_freq), .out_slot(out_slot), .out_last(out_last),
    .commit_pending(commit_pending), .active_count(active_count),
    .sweep_count(sweep_count), .busy(busy)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct packed {logic [3:0] slot; logic [13:0] freq; logic last;} beat_t;
  beat_t exp_q[$];

  int total = 0, bad = 0, cyc = 0, last_hs = 0, max_gap = 0;
  bit seen = 0;
  always @(posedge clk_100MHz) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  beat_t got, want, held;
  logic  stall_prev = 1'b0;
  always @(negedge clk_100MHz) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      got = {out_slot, out_freq, out_last};
      if (stall_prev) chk("stall_hold", {out_valid, got}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("beat_expected", 0, 1);
        else begin
          want = exp_q.pop_front();
          chk("beat", got, want);
        end
        if (seen && (cyc - last_hs) > max_gap) max_gap = cyc - last_hs;
        seen    = 1;
        last_hs = cyc;
      end
      stall_prev = out_valid && !out_ready;
      held       = got;
    end
  end

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic wr(input int s, input int f, input logic [1:0] junk);
    cfg_wr_en   = 1'b1;
    cfg_wr_data = {4'(s), junk, 14'(f)};
    tick();
    cfg_wr_en   = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic push(input int s, input int f, input bit l);
    exp_q.push_back({4'(s), 14'(f), l});
  endtask

  task automatic wait_q(input int n, input string name);
    int b = 0;
    while (exp_q.size() > n && b < 500) begin
      tick();
      b++;
    end
    if (exp_q.size() > n) chk(name, exp_q.size(), n);
  endtask

  task automatic wait_beat(input int s, input string name);
    int b = 0;
    while (!(out_valid && out_slot == 4'(s)) && b < 500) begin
      tick();
      b++;
    end
    if (b >= 500) chk(name, {out_valid, out_slot}, {1'b1, 4'(s)});
  endtask

  task automatic load16();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 16; i++) wr(i, i, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outs", {out_freq, out_slot, out_last}, 0);
    chk("rst_status", {commit_pending, busy, active_count, sweep_count}, 0);

    // Basic 16-slot sweep
    load16();
    do_commit();
    chk("p1_pending", commit_pending, 1);
    repeat (3) tick();
    chk("p1_active_count", active_count, 16);
    chk("p1_pending_clr", commit_pending, 0);
    for (int i = 0; i < 16; i++) push(i, i, i == 15);
    max_gap = 0; seen = 0;
    run = 1'b1; out_ready = 1'b1;
    wait_q(1, "p1_timeout");
    run = 1'b0;
    wait_q(0, "p1_timeout");
    repeat (2) tick();
    chk("p1_gap", max_gap, 1);
    chk("p1_sweep", sweep_count, 1);
    chk("p1_idle", {busy, out_valid}, 0);

    // Sparse table, ignored cfg bits set on slot 2
    clear = 1'b1; tick(); clear = 1'b0;
    wr(2, 'h100, 2'b11);
    wr(5, 'h200, 2'b00);
    wr(9, 'h3FFF, 2'b00);
    do_commit();
    repeat (3) tick();
    chk("p2_active_count", active_count, 3);
    for (int k = 0; k < 2; k++) begin
      push(2, 'h100, 0); push(5, 'h200, 0); push(9, 'h3FFF, 1);
    end
    push(2, 'h100, 0);
    max_gap = 0; seen = 0;
    run = 1'b1;
    wait_q(1, "p2_timeout");
    run = 1'b0;
    wait_q(0, "p2_timeout");
    repeat (2) tick();
    chk("p2_gap", max_gap, 1);
    chk("p2_sweep", sweep_count, 3);

    // Backpressure, run dropped while stalled
    push(2, 'h100, 0); push(5, 'h200, 0); push(9, 'h3FFF, 1);
    push(2, 'h100, 0); push(5, 'h200, 0);
    run = 1'b1;
    for (int k = 0; k < 200 && !(exp_q.size() == 1 && out_valid); k++) begin
      out_ready = (k % 2 == 0);
      tick();
    end
    out_ready = 1'b0;
    tick(); tick();
    run = 1'b0;
    tick(); tick();
    chk("p3_stalled_beat", {out_valid, out_slot}, {1'b1, 4'd5});
    out_ready = 1'b1;
    repeat (3) tick();
    chk("p3_drained", exp_q.size(), 0);
    chk("p3_idle", {busy, out_valid}, 0);
    chk("p3_sweep", sweep_count, 4);

    // Commit deferral across a running sweep
    load16();
    do_commit();
    repeat (3) tick();
    for (int i = 0; i < 16; i++) push(i, i, i == 15);
    push(0, 'h1234, 0); push(1, 1, 0); push(2, 2, 0); push(3, 3, 0);
    max_gap = 0; seen = 0;
    run = 1'b1;
    wait_beat(4, "p4_slot4_timeout");
    cfg_wr_en = 1'b1; cfg_wr_data = {4'd0, 2'b00, 14'h1234}; commit = 1'b1;
    tick();
    cfg_wr_en = 1'b0; commit = 1'b0;
    chk("p4_pending_set", commit_pending, 1);
    wait_beat(15, "p4_slot15_timeout");
    chk("p4_pending_hold", commit_pending, 1);
    wait_q(1, "p4_timeout");
    run = 1'b0;
    wait_q(0, "p4_timeout");
    repeat (3) tick();
    chk("p4_swap_gap", max_gap, 3);
    chk("p4_pending_clr", commit_pending, 0);
    chk("p4_sweep", sweep_count, 5);

    // Clear with same-cycle write, then empty table
    clear = 1'b1; cfg_wr_en = 1'b1; cfg_wr_data = {4'd3, 2'b00, 14'd7};
    tick();
    clear = 1'b0; cfg_wr_en = 1'b0;
    do_commit();
    repeat (3) tick();
    chk("p5_active_count", active_count, 1);
    for (int k = 0; k < 4; k++) push(3, 7, 1);
    run = 1'b1;
    wait_q(1, "p5_timeout");
    out_ready = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    do_commit();
    out_ready = 1'b1;
    wait_q(0, "p5_timeout");
    repeat (5) tick();
    chk("p5_empty_count", active_count, 0);
    chk("p5_empty_idle", {busy, out_valid}, 0);
    chk("p5_sweep", sweep_count, 9);
    repeat (10) tick();
    chk("p5_no_beats", out_valid, 0);

    // Reset mid-stream with a commit pending
    wr(1, 'h55, 2'b00);
    wr(6, 'h66, 2'b00);
    push(1, 'h55, 0); push(6, 'h66, 1); push(1, 'h55, 0);
    do_commit();
    wait_q(1, "p6_timeout");
    out_ready = 1'b0;
    do_commit();
    chk("p6_pending", commit_pending, 1);
    chk("p6_sweep_pre", sweep_count, 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("p6_rst_valid", out_valid, 0);
    chk("p6_rst_status", {commit_pending, busy, active_count, sweep_count}, 0);
    out_ready = 1'b1;
    repeat (20) tick();
    chk("p6_no_beats", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
